// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - fetch_state_e : fetch FSM states (RESET, FETCH, DRAIN)
//   - JMP_*         : decode JMPSel encodings
//   - NOP_INSTR     : value the IF/ID register holds when empty
//   - PC_W          : PC / instruction-address width
//   - sat_inc       : saturating add used by the performance counters
package fetch_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_ABS = 2'b01;
    localparam logic [1:0] JMP_REG = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] sat_inc(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for a fetch response that arrives
// while IF/ID is stalled with a live instruction.
//   clk, rst (async, active-low)
//   push/push_instr/push_pc : capture an entry
//   pop                     : entry moved to IF/ID
//   clear                   : redirect, drop the entry (wins over push/pop)
//   instr/pc/valid          : current contents
module fetch_skid
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [31:0]     push_instr,
    input  logic [PC_W-1:0] push_pc,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            valid
);

    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            instr_d = push_instr;
            pc_d    = push_pc;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches one word per cycle from instruction
// memory over a req/ack handshake and fills the IF/ID register.
//   Params : RESET_PC (PC after reset), PC_STEP (sequential increment)
//   In     : clk, rst (async, active-low), stall, JMPSel/jmp_addr/jreg_addr
//            (decode jumps), branch_taken/branch_target (EX branches),
//            imem_ack/imem_rdata (memory response, ack may be combinational)
//   Out    : imem_req/imem_addr, instruction/pc_out/instr_valid (IF/ID),
//            flush_idex, perf_fetched/perf_squashed
// Build option: define FETCH_PERF_CNT_EN to get saturating fetch/squash
// counters; otherwise the perf outputs are tied to 0.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      JMPSel,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic [PC_W-1:0] jreg_addr,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    output logic            flush_idex,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;            // next address to fetch
    logic            imem_req_q, imem_req_d;
    logic [PC_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;

    logic            skid_push, skid_pop, skid_clear, skid_full_d;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            skid_valid;

    logic            ack_acc, jmp_hit, redirect;
    logic [PC_W-1:0] redir_pc;

    assign ack_acc  = imem_req_q && imem_ack;
    // Jumps come from the instruction in decode, which only advances when unstalled.
    assign jmp_hit  = !stall && ((JMPSel == JMP_ABS) || (JMPSel == JMP_REG));
    assign redirect = branch_taken || jmp_hit;
    assign redir_pc = branch_taken           ? branch_target :
                      (JMPSel == JMP_ABS)    ? jmp_addr      : jreg_addr;

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (skid_clear),
        .push_instr (imem_rdata),
        .push_pc    (imem_addr_q),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .valid      (skid_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;

        if (redirect) begin
            // Any response arriving now is wrong-path; if the request is still
            // open it must be seen through to its ack before the target goes out.
            pc_d       = redir_pc;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            state_d    = (imem_req_q && !imem_ack) ? ST_DRAIN : ST_FETCH;
        end else if (state_q == ST_RESET) begin
            state_d = ST_FETCH;
        end else if (state_q == ST_DRAIN) begin
            // IF/ID and skid were emptied by the redirect; just wait for the ack.
            if (imem_ack) state_d = ST_FETCH;
        end else begin
            if (!stall && skid_valid) begin
                // No request is open while the skid is full, so no ack can collide.
                instr_d  = skid_instr;
                pc_out_d = skid_pc;
                valid_d  = 1'b1;
                skid_pop = 1'b1;
            end else if (ack_acc && (!stall || !valid_q)) begin
                instr_d  = imem_rdata;
                pc_out_d = imem_addr_q;
                valid_d  = 1'b1;
            end else if (ack_acc) begin
                skid_push = 1'b1;
            end else if (!stall) begin
                valid_d = 1'b0;   // decode consumed IF/ID, nothing new arrived
            end
            if (ack_acc) pc_d = pc_q + PC_STEP;
        end

        skid_full_d = skid_push || (skid_valid && !skid_pop && !skid_clear);
        imem_req_d  = (state_d == ST_DRAIN) || ((state_d == ST_FETCH) && !skid_full_d);
        // DRAIN keeps the abandoned address on the bus until memory answers.
        imem_addr_d = (state_d == ST_DRAIN) ? imem_addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RESET;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign flush_idex  = branch_taken;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic [1:0]  squash_inc;

    always_comb begin
        squash_inc = 2'd0;
        // On a jump, IF/ID holds the jump itself (consumed), so only a branch
        // discards it; a skid entry is wrong-path under either redirect.
        if (redirect)
            squash_inc = {1'b0, branch_taken && valid_q} + {1'b0, skid_valid};
        if ((state_q == ST_DRAIN) && ack_acc)
            squash_inc = squash_inc + 2'd1;
        perf_fetched_d  = sat_inc(perf_fetched_q, {1'b0, ack_acc});
        perf_squashed_d = sat_inc(perf_squashed_q, squash_inc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`else
    assign perf_fetched  = '0;
    assign perf_squashed = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero-wait streaming, jump bubble,
// stall/skid, branch with DRAIN, register jump with PC wrap, JMPSel=11, and
// asynchronous reset mid-fetch. Memory answers with addr ^ DEADBEEF after a
// programmable number of wait cycles (0 = combinational ack).
module tb_instr_fetch;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst, stall, branch_taken;
    logic [1:0]  jmp_sel;
    logic [31:0] jmp_addr, jreg_addr, branch_target;
    logic        imem_req, imem_ack, instr_valid, flush_idex;
    logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
    logic [31:0] perf_fetched, perf_squashed;

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 0;
    int wcnt;

    instr_fetch #(.RESET_PC(32'h10), .PC_STEP(32'd1)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .JMPSel        (jmp_sel),
        .jmp_addr      (jmp_addr),
        .jreg_addr     (jreg_addr),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .flush_idex    (flush_idex),
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst)                       wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    assign imem_ack   = imem_req && (wcnt >= mem_lat);
    assign imem_rdata = mw(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_ins"}, instruction, mw(pc));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h10);
        chk({tag, "_ins"}, instruction, 32'h0);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_pf"}, perf_fetched, 32'd0);
        chk({tag, "_ps"}, perf_squashed, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jmp_sel = 2'b00; jmp_addr = '0; jreg_addr = '0;
        branch_taken = 1'b0; branch_target = '0;
        #1 rst = 1'b0;
        #2 chk_reset("rst");

        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("c0_req", {31'b0, imem_req}, 32'd0);

        // zero-wait streaming from 0x10
        tick; chk("c1_req", {31'b0, imem_req}, 32'd1); chk("c1_addr", imem_addr, 32'h10);
              chk("c1_vld", {31'b0, instr_valid}, 32'd0);
        tick; chk_ifid("c2", 32'h10); chk("c2_addr", imem_addr, 32'h11);
        tick; chk_ifid("c3", 32'h11); chk("c3_addr", imem_addr, 32'h12);
        tick; chk_ifid("c4", 32'h12); chk("c4_addr", imem_addr, 32'h13);

        // absolute jump decoded at PC 0x13
        tick; jmp_sel = 2'b01; jmp_addr = 32'h40; #1;
              chk_ifid("c5", 32'h13); chk("c5_addr", imem_addr, 32'h14);
              chk("c5_flush", {31'b0, flush_idex}, 32'd0);
        tick; jmp_sel = 2'b00; #1;
              chk("c6_vld", {31'b0, instr_valid}, 32'd0); chk("c6_addr", imem_addr, 32'h40);
              chk("c6_req", {31'b0, imem_req}, 32'd1);
        tick; chk_ifid("c7", 32'h40);

        // three stall cycles with a response in flight
        tick; stall = 1'b1; #1;
              chk_ifid("c8", 32'h41); chk("c8_req", {31'b0, imem_req}, 32'd1);
              chk("c8_addr", imem_addr, 32'h42);
        tick; chk_ifid("c9", 32'h41); chk("c9_req", {31'b0, imem_req}, 32'd0);
        tick; chk_ifid("c10", 32'h41); chk("c10_req", {31'b0, imem_req}, 32'd0);
        tick; stall = 1'b0; #1;
              chk_ifid("c11", 32'h41); chk("c11_req", {31'b0, imem_req}, 32'd0);
        tick; chk_ifid("c12", 32'h42); chk("c12_addr", imem_addr, 32'h43);
              chk("c12_req", {31'b0, imem_req}, 32'd1);

        // branch under stall with a 2-wait request outstanding
        tick; stall = 1'b1; mem_lat = 2; #1;
              chk_ifid("c13", 32'h43); chk("c13_addr", imem_addr, 32'h44);
        tick; branch_taken = 1'b1; branch_target = 32'h80; #1;
              chk("c14_flush", {31'b0, flush_idex}, 32'd1); chk_ifid("c14", 32'h43);
        tick; branch_taken = 1'b0; stall = 1'b0; #1;
              chk("c15_flush", {31'b0, flush_idex}, 32'd0);
              chk("c15_vld", {31'b0, instr_valid}, 32'd0);
              chk("c15_req", {31'b0, imem_req}, 32'd1); chk("c15_addr", imem_addr, 32'h44);
        tick; mem_lat = 0; #1;
              chk("c16_vld", {31'b0, instr_valid}, 32'd0); chk("c16_addr", imem_addr, 32'h80);
              chk("c16_ps", perf_squashed, PERF ? 32'd2 : 32'd0);
              chk("c16_pf", perf_fetched, PERF ? 32'd10 : 32'd0);

        // register jump to the top of the address space, then wrap
        tick; jmp_sel = 2'b10; jreg_addr = 32'hFFFF_FFFE; jmp_addr = 32'h1234; #1;
              chk_ifid("c17", 32'h80);
        tick; jmp_sel = 2'b00; #1;
              chk("c18_vld", {31'b0, instr_valid}, 32'd0); chk("c18_addr", imem_addr, 32'hFFFF_FFFE);
        tick; chk_ifid("c19", 32'hFFFF_FFFE); chk("c19_addr", imem_addr, 32'hFFFF_FFFF);
        tick; chk_ifid("c20", 32'hFFFF_FFFF); chk("c20_addr", imem_addr, 32'h0);

        // JMPSel=11 behaves as sequential
        tick; jmp_sel = 2'b11; jmp_addr = 32'h55; #1;
              chk_ifid("c21", 32'h0); chk("c21_addr", imem_addr, 32'h1);
        tick; chk_ifid("c22", 32'h1); chk("c22_addr", imem_addr, 32'h2);
              chk("c22_req", {31'b0, imem_req}, 32'd1);

        // asynchronous reset while a request is up
        rst = 1'b0; #1;
        chk_reset("arst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
